// File: rtl/reader_cmdtx_if.sv
// rtl/reader_cmdtx_if.sv - command request and serial bit stream bundle for reader_cmdtx
interface reader_cmdtx_if;
  logic        start;
  logic [3:0]  cmd_sel;
  logic [33:0] args;
  logic        crc_corrupt;
  logic        txbit;
  logic        txvalid;
  logic        busy;
  logic        done;
  logic        badcmd;

  modport master (
    output start, cmd_sel, args, crc_corrupt,
    input  txbit, txvalid, busy, done, badcmd
  );

  modport slave (
    input  start, cmd_sel, args, crc_corrupt,
    output txbit, txvalid, busy, done, badcmd
  );
endinterface

// File: rtl/reader_cmdtx.sv
// rtl/reader_cmdtx.sv - reader command serializer with CRC5/CRC16; final CRC bit corruption under CMDTX_CRC_CORRUPT_EN
module reader_cmdtx (
  input logic           bitclk,
  input logic           reset,
  reader_cmdtx_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_ARGS   = 3'd2;
  localparam logic [2:0] S_CRC    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] CRC_NONE = 2'd0;
  localparam logic [1:0] CRC_5    = 2'd1;
  localparam logic [1:0] CRC_16   = 2'd2;

  localparam logic [4:0]  CRC5_PRESET  = 5'b01001;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [7:0]  op_sh;
  logic [33:0] args_sh;
  logic [5:0]  arg_len;
  logic [1:0]  crc_sel;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        badcmd_r;
  logic        cur_bit;
  logic        sending;

  logic        cmd_ok;
  logic [7:0]  op_n;
  logic [5:0]  op_len_n;
  logic [5:0]  arg_len_n;
  logic [1:0]  crc_n;

  logic [4:0]  crc5_step;
  logic [15:0] crc16_step;
  logic [5:0]  crc_last;

`ifdef CMDTX_CRC_CORRUPT_EN
  logic        corrupt_r;
`else
  logic        unused_crc_corrupt;
  assign unused_crc_corrupt = bus.crc_corrupt;
`endif

  // Frame table lookup: opcode left-justified in 8 bits, opcode/arg lengths, CRC kind
  always_comb begin
    cmd_ok    = 1'b1;
    op_n      = 8'h00;
    op_len_n  = 6'd2;
    arg_len_n = 6'd0;
    crc_n     = CRC_NONE;
    case (bus.cmd_sel)
      4'd0: begin op_n = 8'b0000_0000; op_len_n = 6'd2; arg_len_n = 6'd2;  end
      4'd1: begin op_n = 8'b0100_0000; op_len_n = 6'd2; arg_len_n = 6'd16; end
      4'd2: begin op_n = 8'b1000_0000; op_len_n = 6'd4; arg_len_n = 6'd13; crc_n = CRC_5; end
      4'd3: begin op_n = 8'b1001_0000; op_len_n = 6'd4; arg_len_n = 6'd5;  end
      4'd4: begin op_n = 8'b1100_0000; op_len_n = 6'd8; arg_len_n = 6'd0;  end
      4'd5: begin op_n = 8'b1100_0001; op_len_n = 6'd8; arg_len_n = 6'd16; crc_n = CRC_16; end
      4'd6: begin op_n = 8'b1100_0010; op_len_n = 6'd8; arg_len_n = 6'd34; crc_n = CRC_16; end
      default: cmd_ok = 1'b0;
    endcase
  end

  // Bit on the wire this cycle; the CRC16 is sent complemented, the CRC5 as-is
  always_comb begin
    cur_bit = 1'b0;
    case (state)
      S_OPCODE: cur_bit = op_sh[7];
      S_ARGS:   cur_bit = args_sh[33];
      S_CRC:    cur_bit = (crc_sel == CRC_5) ? crc5[4] : ~crc16[15];
      default:  cur_bit = 1'b0;
    endcase
`ifdef CMDTX_CRC_CORRUPT_EN
    if (state == S_CRC && cnt == 6'd0 && corrupt_r)
      cur_bit = ~cur_bit;
`endif
  end

  assign sending    = (state == S_OPCODE) || (state == S_ARGS) || (state == S_CRC);
  assign crc5_step  = {crc5[3:0], 1'b0} ^ ({5{crc5[4] ^ cur_bit}} & 5'b01001);
  assign crc16_step = {crc16[14:0], 1'b0} ^ ({16{crc16[15] ^ cur_bit}} & 16'h1021);
  assign crc_last   = (crc_sel == CRC_5) ? 6'd4 : 6'd15;

  assign bus.txvalid = sending;
  assign bus.txbit   = sending & cur_bit;
  assign bus.busy    = sending;
  assign bus.done    = (state == S_DONE);
  assign bus.badcmd  = badcmd_r;

  // Frame sequencer: cnt holds remaining bits minus one in the current field
  always_ff @(posedge bitclk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      op_sh    <= 8'h00;
      args_sh  <= 34'h0;
      arg_len  <= 6'd0;
      crc_sel  <= CRC_NONE;
      crc5     <= CRC5_PRESET;
      crc16    <= CRC16_PRESET;
      badcmd_r <= 1'b0;
`ifdef CMDTX_CRC_CORRUPT_EN
      corrupt_r <= 1'b0;
`endif
    end else begin
      badcmd_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (cmd_ok) begin
              state   <= S_OPCODE;
              cnt     <= op_len_n - 6'd1;
              op_sh   <= op_n;
              args_sh <= bus.args << (6'd34 - arg_len_n);
              arg_len <= arg_len_n;
              crc_sel <= crc_n;
              crc5    <= CRC5_PRESET;
              crc16   <= CRC16_PRESET;
`ifdef CMDTX_CRC_CORRUPT_EN
              corrupt_r <= bus.crc_corrupt;
`endif
            end else begin
              badcmd_r <= 1'b1;
            end
          end
        end
        S_OPCODE: begin
          op_sh <= {op_sh[6:0], 1'b0};
          crc5  <= crc5_step;
          crc16 <= crc16_step;
          cnt   <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            if (arg_len != 6'd0) begin
              state <= S_ARGS;
              cnt   <= arg_len - 6'd1;
            end else if (crc_sel != CRC_NONE) begin
              state <= S_CRC;
              cnt   <= crc_last;
            end else begin
              state <= S_DONE;
              cnt   <= 6'd0;
            end
          end
        end
        S_ARGS: begin
          args_sh <= {args_sh[32:0], 1'b0};
          crc5    <= crc5_step;
          crc16   <= crc16_step;
          cnt     <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            if (crc_sel != CRC_NONE) begin
              state <= S_CRC;
              cnt   <= crc_last;
            end else begin
              state <= S_DONE;
              cnt   <= 6'd0;
            end
          end
        end
        S_CRC: begin
          crc5  <= {crc5[3:0], 1'b0};
          crc16 <= {crc16[14:0], 1'b0};
          cnt   <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            state <= S_DONE;
            cnt   <= 6'd0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= 6'd0;
          crc5  <= CRC5_PRESET;
          crc16 <= CRC16_PRESET;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reader_cmdtx.sv
// tb/tb_reader_cmdtx.sv - directed vector bench for reader_cmdtx
module tb_reader_cmdtx;
  logic bitclk;
  logic reset;
  int   checks;
  int   errors;

  reader_cmdtx_if bus ();

  reader_cmdtx dut (
    .bitclk (bitclk),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    bitclk = 1'b0;
    forever #5 bitclk = ~bitclk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [33:0] args;
    int          repulse;
    int          exp_len;
    logic [63:0] exp_msg;
    int          crc_bits;
    logic [15:0] exp_res;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] rx;
  int          n;
  logic [15:0] res;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] res5(input logic [63:0] bits, input int len);
    logic [4:0] c;
    logic fb;
    c = 5'b01001;
    for (int i = len - 1; i >= 0; i--) begin
      fb = c[4] ^ bits[i];
      c  = {c[3:0], 1'b0} ^ ({5{fb}} & 5'b01001);
    end
    return {11'h0, c};
  endfunction

  function automatic logic [15:0] res16(input logic [63:0] bits, input int len);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = len - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
    end
    return c;
  endfunction

  // Called just after a negedge; returns just after the negedge of the idle cycle following DONE
  task automatic send(input string nm, input logic [3:0] cmd, input logic [33:0] a,
                      input logic corrupt, input int repulse, input int abort_at,
                      output logic [63:0] bits, output int len);
    int guard;
    bits = '0;
    len  = 0;
    bus.start = 1'b1; bus.cmd_sel = cmd; bus.args = a; bus.crc_corrupt = corrupt;
    @(posedge bitclk);
    @(negedge bitclk);
    bus.start = 1'b0; bus.cmd_sel = ~cmd; bus.args = ~a; bus.crc_corrupt = ~corrupt;
    check({nm, " busy first"}, 64'(bus.busy), 64'd1);
    guard = 0;
    while (bus.txvalid === 1'b1 && guard < 100) begin
      bits = {bits[62:0], bus.txbit};
      len++;
      if (len == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check({nm, " txvalid at abort"}, 64'(bus.txvalid), 64'd0);
        check({nm, " busy at abort"}, 64'(bus.busy), 64'd0);
        return;
      end
      bus.start = (len == repulse);
      @(negedge bitclk);
      guard++;
    end
    bus.start = 1'b0;
    check({nm, " done pulse"}, 64'(bus.done), 64'd1);
    check({nm, " busy in done"}, 64'(bus.busy), 64'd0);
    check({nm, " txbit in done"}, 64'(bus.txbit), 64'd0);
    @(negedge bitclk);
    check({nm, " done one cycle"}, 64'(bus.done), 64'd0);
    check({nm, " idle txvalid"}, 64'(bus.txvalid), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.cmd_sel = 4'd0; bus.args = 34'h0; bus.crc_corrupt = 1'b0;

    vecs[0] = '{"queryrep", 4'd0, 34'h1,         -1, 4,  64'h1,           0,  16'h0};
    vecs[1] = '{"ack",      4'd1, 34'h2A5A51234, -1, 18, 64'h11234,       0,  16'h0};
    vecs[2] = '{"query0",   4'd2, 34'h0,         -1, 22, 64'h10000,       5,  16'h0};
    vecs[3] = '{"query1",   4'd2, 34'h3FFFFFABC, -1, 22, 64'h11ABC,       5,  16'h0};
    vecs[4] = '{"queryadj", 4'd3, 34'h16,        -1, 9,  64'h136,         0,  16'h0};
    vecs[5] = '{"nack",     4'd4, 34'h3FFFFFFFF, -1, 8,  64'hC0,          0,  16'h0};
    vecs[6] = '{"reqrn",    4'd5, 34'hABCD,      -1, 40, 64'hC1ABCD,      16, 16'h1D0F};
    vecs[7] = '{"read",     4'd6, 34'h212345678, 10, 58, 64'h30A12345678, 16, 16'h1D0F};

    repeat (2) @(negedge bitclk);
    check("reset txvalid", 64'(bus.txvalid), 64'd0);
    check("reset txbit",   64'(bus.txbit),   64'd0);
    check("reset busy",    64'(bus.busy),    64'd0);
    check("reset done",    64'(bus.done),    64'd0);
    check("reset badcmd",  64'(bus.badcmd),  64'd0);
    reset = 1'b0;

    bus.start = 1'b1; bus.cmd_sel = 4'd9;
    @(negedge bitclk);
    bus.start = 1'b0;
    check("badcmd pulse",   64'(bus.badcmd),  64'd1);
    check("badcmd busy",    64'(bus.busy),    64'd0);
    check("badcmd txvalid", 64'(bus.txvalid), 64'd0);
    @(negedge bitclk);
    check("badcmd once",    64'(bus.badcmd),  64'd0);
    check("badcmd idle",    64'(bus.txvalid), 64'd0);

    for (int v = 0; v < 8; v++) begin
      send(vecs[v].name, vecs[v].cmd, vecs[v].args, 1'b0, vecs[v].repulse, -1, rx, n);
      check({vecs[v].name, " length"}, 64'(n), 64'(vecs[v].exp_len));
      check({vecs[v].name, " message"}, rx >> vecs[v].crc_bits, vecs[v].exp_msg);
      if (vecs[v].crc_bits == 5)
        check({vecs[v].name, " crc5 residue"}, 64'(res5(rx, n)), 64'(vecs[v].exp_res));
      else if (vecs[v].crc_bits == 16)
        check({vecs[v].name, " crc16 residue"}, 64'(res16(rx, n)), 64'(vecs[v].exp_res));
    end

    send("reqrn_corrupt", 4'd5, 34'hABCD, 1'b1, -1, -1, rx, n);
    check("reqrn_corrupt length", 64'(n), 64'd40);
    res = res16(rx, n);
`ifdef CMDTX_CRC_CORRUPT_EN
    checks++;
    if (res === 16'h1D0F) begin
      errors++;
      $display("FAIL reqrn_corrupt residue: got %0h required anything but 1d0f", res);
    end
`else
    check("reqrn_corrupt residue", 64'(res), 64'h1D0F);
`endif

    send("read_abort", 4'd6, 34'h155555555, 1'b0, -1, 30, rx, n);
    check("read_abort bits", 64'(n), 64'd30);
    for (int k = 0; k < 3; k++) begin
      @(posedge bitclk);
      #1;
      check("abort no done", 64'(bus.done), 64'd0);
      check("abort txvalid", 64'(bus.txvalid), 64'd0);
    end
    @(negedge bitclk);
    reset = 1'b0;
    send("nack_after_abort", 4'd4, 34'h0, 1'b0, -1, -1, rx, n);
    check("nack_after_abort length", 64'(n), 64'd8);
    check("nack_after_abort bits", rx, 64'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
